// File: rtl/seven_seg_capture_pkg.sv
// Shared display package: hex segment table, digit-select bit index and the
// capture FSM state encoding. The display driver imports the same package,
// so both sides always agree on the segment layout.
package seven_seg_capture_pkg;

  // Bit of the display bus that selects the digit: 0 = MSB digit, 1 = LSB digit.
  localparam int SEL_BIT = 7;

  // Active-high segment patterns g..a for hex digits 0..F, indexed by nibble.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Bus bundle between a multiplexed seven-segment display and the capture block.
//   seg_in     : [6:0] active-low segments g..a, [7] digit select
//   dout       : last captured two-digit value, MSB nibble in [7:4]
//   dout_valid : one-cycle pulse when dout takes a new value
//   dout_err   : one-cycle pulse on an undecodable segment pattern
//   locked     : high while valid frames are being received
// master = side that drives the display bus, slave = the capture block.
interface seven_seg_capture_if;
  logic [7:0] seg_in;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_err;
  logic       locked;

  modport master (output seg_in, input dout, dout_valid, dout_err, locked);
  modport slave  (input seg_in, output dout, dout_valid, dout_err, locked);
endinterface

// File: rtl/seven_seg_capture_unhex.sv
// Combinational pattern-to-nibble decode.
//   pattern : 7-bit active-high segment pattern g..a
//   nibble  : hex value of the pattern (0 when invalid)
//   valid   : pattern matches an entry of the hex segment table
module seven_seg_unhex
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  // Table entries are unique, so at most one iteration matches.
  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == HEX_SEG[i]) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a two-digit hex value from a multiplexed seven-segment display bus.
// The bus is synchronized, each stable digit is sampled once it has been
// unchanged for SETTLE cycles, and MSB-then-LSB pairs form a frame.
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : seven_seg_capture_if.slave (seg_in in; dout, dout_valid,
//            dout_err, locked out)
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                resetn,
  seven_seg_capture_if.slave  bus
);

  localparam int SCNT_W = $clog2(SETTLE + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  logic [7:0]        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  cap_state_e        state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]        msb_q, msb_d;
  logic              have_msb_q, have_msb_d;
  logic              first_q, first_d;
  logic [7:0]        dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_err_q, dout_err_d;
  logic              locked_q, locked_d;

  logic [3:0]        unhex_nib;
  logic              unhex_valid;
  logic              change, sample, expire;
  logic [7:0]        frame;

  seven_seg_unhex u_unhex (
    .pattern (~sync2_q[6:0]),
    .nibble  (unhex_nib),
    .valid   (unhex_valid)
  );

  // prev_q holds the synchronized bus one cycle back, giving the change strobe.
  assign change = (sync2_q != prev_q);
  assign sample = (state_q == ST_SETTLE) && !change &&
                  (scnt_q == SCNT_W'(SETTLE - 1));
  // A bus change in the expiry cycle wins: expire is masked by change.
  assign expire = !change && (tcnt_q == TCNT_W'(TIMEOUT - 1));
  assign frame  = {msb_q, unhex_nib};

  always_comb begin
    sync1_d      = bus.seg_in;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    state_d      = state_q;
    scnt_d       = scnt_q;
    msb_d        = msb_q;
    have_msb_d   = have_msb_q;
    first_d      = first_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_err_d   = 1'b0;
    locked_d     = locked_q;

    // Saturating idle counter; never wraps back into a spurious expiry.
    if (change)
      tcnt_d = '0;
    else if (tcnt_q != TCNT_W'(TIMEOUT))
      tcnt_d = tcnt_q + TCNT_W'(1);
    else
      tcnt_d = tcnt_q;

    case (state_q)
      ST_SETTLE: begin
        if (change)
          scnt_d = '0;
        else if (sample)
          state_d = ST_HOLD;
        else
          scnt_d = scnt_q + SCNT_W'(1);
      end
      default: begin
        if (change) begin
          state_d = ST_SETTLE;
          scnt_d  = '0;
        end
      end
    endcase

    if (sample) begin
      if (!unhex_valid) begin
        dout_err_d = 1'b1;
        have_msb_d = 1'b0;
      end else if (!sync2_q[SEL_BIT]) begin
        msb_d      = unhex_nib;
        have_msb_d = 1'b1;
      end else if (have_msb_q) begin
        // LSB without a preceding MSB falls through and is dropped.
        have_msb_d = 1'b0;
        locked_d   = 1'b1;
        if (first_q || (frame != dout_q)) begin
          dout_d       = frame;
          dout_valid_d = 1'b1;
          first_d      = 1'b0;
        end
      end
    end

    if (expire) begin
      locked_d   = 1'b0;
      state_d    = ST_HUNT;
      have_msb_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      state_q      <= ST_HUNT;
      scnt_q       <= '0;
      tcnt_q       <= '0;
      msb_q        <= '0;
      have_msb_q   <= 1'b0;
      first_q      <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      tcnt_q       <= tcnt_d;
      msb_q        <= msb_d;
      have_msb_q   <= have_msb_d;
      first_q      <= first_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_err_q   <= dout_err_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_err   = dout_err_q;
  assign bus.locked     = locked_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: frame capture and latency, repeated
// frames, glitch rejection, invalid patterns, lock timeout and reset mid-settle.
module tb_seven_seg_capture;

  localparam int S   = 4;
  localparam int T   = 4096;
  localparam int LAT = 2 + S + 1;

  logic clk;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;
  int   vcnt     = 0;
  int   ecnt     = 0;
  int   v0, e0;

  seven_seg_capture_if bus_if ();

  seven_seg_capture #(.SETTLE(S), .TIMEOUT(T)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (resetn && bus_if.dout_valid) vcnt++;
    if (resetn && bus_if.dout_err)   ecnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    bus_if.seg_in = 8'h00;
    wait_n(3);
    check("rst_dout",   16'(bus_if.dout),       16'h00);
    check("rst_valid",  16'(bus_if.dout_valid), 16'h0);
    check("rst_err",    16'(bus_if.dout_err),   16'h0);
    check("rst_locked", 16'(bus_if.locked),     16'h0);
    resetn = 1'b1;

    // MSB "4" then LSB "2": frame 0x42, pulse exactly LAT cycles after 0xA4.
    bus_if.seg_in = 8'h19;
    wait_n(50);
    check("msb_only_locked", 16'(bus_if.locked), 16'h0);
    check("msb_only_dout",   16'(bus_if.dout),   16'h00);
    v0 = vcnt;
    bus_if.seg_in = 8'hA4;
    wait_n(LAT - 1);
    check("lat_early_valid", 16'(bus_if.dout_valid), 16'h0);
    wait_n(1);
    check("lat_valid",  16'(bus_if.dout_valid), 16'h1);
    check("lat_dout",   16'(bus_if.dout),       16'h42);
    check("lat_locked", 16'(bus_if.locked),     16'h1);
    wait_n(1);
    check("lat_pulse_end", 16'(bus_if.dout_valid), 16'h0);
    wait_n(50 - LAT - 1);
    check("frame_pulses", 16'(vcnt - v0), 16'd1);

    // Identical frame repeated: no further pulses.
    v0 = vcnt;
    for (int i = 0; i < 10; i++) begin
      bus_if.seg_in = 8'h19; wait_n(50);
      bus_if.seg_in = 8'hA4; wait_n(50);
    end
    check("repeat_pulses", 16'(vcnt - v0), 16'd0);
    check("repeat_dout",   16'(bus_if.dout), 16'h42);
    check("repeat_locked", 16'(bus_if.locked), 16'h1);

    // Short glitch during HOLD is never sampled.
    bus_if.seg_in = 8'h19; wait_n(50);
    v0 = vcnt; e0 = ecnt;
    bus_if.seg_in = 8'h00; wait_n(2);
    bus_if.seg_in = 8'h19; wait_n(30);
    check("glitch_err",   16'(ecnt - e0), 16'd0);
    check("glitch_valid", 16'(vcnt - v0), 16'd0);
    check("glitch_dout",  16'(bus_if.dout), 16'h42);

    // Blank MSB is an error and drops the pending MSB; following LSB discarded.
    bus_if.seg_in = 8'h7F; wait_n(50);
    check("blank_err", 16'(ecnt - e0), 16'd1);
    bus_if.seg_in = 8'hA4; wait_n(50);
    check("orphan_lsb_valid", 16'(vcnt - v0), 16'd0);
    check("orphan_lsb_dout",  16'(bus_if.dout), 16'h42);
    check("orphan_lsb_err",   16'(ecnt - e0), 16'd1);

    // New frame "A","F" -> 0xAF; 0x8E is also the last bus change before timeout.
    bus_if.seg_in = 8'h08; wait_n(50);
    bus_if.seg_in = 8'h8E;
    wait_n(LAT);
    check("af_valid", 16'(bus_if.dout_valid), 16'h1);
    check("af_dout",  16'(bus_if.dout),       16'hAF);

    // Lock lost T cycles after the synchronized change is registered
    // (applied at this negedge: falls at edge +T+3).
    wait_n(T + 2 - LAT);
    check("to_before_locked", 16'(bus_if.locked), 16'h1);
    wait_n(1);
    check("to_fall_locked", 16'(bus_if.locked), 16'h0);
    wait_n(8);
    check("to_after_locked", 16'(bus_if.locked), 16'h0);
    check("to_dout_kept",    16'(bus_if.dout),   16'hAF);

    // Reset mid-SETTLE, then a "0","0" frame must still pulse.
    bus_if.seg_in = 8'h19;
    wait_n(4);
    resetn = 1'b0;
    #1;
    check("mid_rst_dout",   16'(bus_if.dout),       16'h00);
    check("mid_rst_locked", 16'(bus_if.locked),     16'h0);
    check("mid_rst_valid",  16'(bus_if.dout_valid), 16'h0);
    bus_if.seg_in = 8'h40;
    wait_n(2);
    resetn = 1'b1;
    v0 = vcnt;
    wait_n(50);
    check("post_rst_msb_valid", 16'(vcnt - v0), 16'd0);
    bus_if.seg_in = 8'hC0;
    wait_n(LAT);
    check("zero_valid",  16'(bus_if.dout_valid), 16'h1);
    check("zero_dout",   16'(bus_if.dout),       16'h00);
    check("zero_locked", 16'(bus_if.locked),     16'h1);
    wait_n(20);
    check("zero_pulses", 16'(vcnt - v0), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
